// File: rtl/buffer_read_streamer_pkg.sv
// Shared definitions for the buffer read streamer.
//   FSIZE               : bits per buffer word
//   BUFFER_READ_LATENCY : read latency of the buffer RAMs in cycles
//   brs_state_t         : streamer FSM state encoding
package buffer_read_streamer_pkg;

    localparam int FSIZE               = 16;
    localparam int BUFFER_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } brs_state_t;

endpackage

// File: rtl/buffer_read_streamer_stream_fifo.sv
// First-word-fall-through FIFO with occupancy count.
//   clk, rstn  : clock, asynchronous active-low reset
//   push       : write push_data this cycle
//   pop        : consume the head entry this cycle (only when valid)
//   pop_data   : head entry, valid whenever valid=1
//   valid      : FIFO not empty
//   count      : current number of entries
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_data = mem[rd_ptr];
    assign valid    = (count != '0);

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/buffer_read_streamer.sv
// Read-side sequencer for the on-chip buffer RAMs. Accepts (base, length)
// commands, issues consecutive row reads, tracks the RAM read latency and
// returns the rows as a valid/ready stream with a last flag.
//   clk, rstn           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_base, cmd_len   : first row and row count (0..DEPTH)
//   raddr, rdata        : RAM read address / read data
//   out_valid/out_ready : row stream handshake
//   out_data, out_last  : row data and final-row flag
//   busy                : FSM not idle
module buffer_read_streamer
    import buffer_read_streamer_pkg::*;
#(
    parameter int DEPTH        = 512,
    parameter int WIDTH        = FSIZE,
    parameter int WORDS        = 32,
    parameter int READ_LATENCY = BUFFER_READ_LATENCY,
    parameter int DEPTHAD      = $clog2(DEPTH),
    parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [DEPTHAD-1:0]       cmd_base,
    input  logic [DEPTHAD:0]         cmd_len,
    output logic [DEPTHAD-1:0]       raddr,
    input  logic [WIDTH*WORDS-1:0]   rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*WORDS-1:0]   out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int RW = WIDTH * WORDS;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [DEPTHAD:0] LEN_ONE = 1;

    brs_state_t              state;
    logic [DEPTHAD:0]        remain;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [READ_LATENCY-1:0] trk_v;
    logic [READ_LATENCY-1:0] trk_l;

    logic credit_ok;
    logic issue;
    logic issue_last;
    logic push;
    logic pop;

    // Reads in the RAM pipeline plus rows already buffered must leave room
    // for one more, so every issued read is guaranteed a FIFO slot.
    assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign issue      = (state == ISSUE) && credit_ok;
    assign issue_last = (remain == LEN_ONE);
    assign push       = trk_v[READ_LATENCY-1];
    assign pop        = out_valid && out_ready;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            raddr  <= '0;
            remain <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Zero-length commands are accepted and dropped.
                    if (cmd_valid && (cmd_len != '0)) begin
                        state  <= ISSUE;
                        raddr  <= cmd_base;
                        remain <= cmd_len;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        raddr  <= (raddr == DEPTHAD'(DEPTH - 1)) ? '0 : raddr + 1'b1;
                        remain <= remain - 1'b1;
                        if (issue_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Latency tracker: one {valid,last} slot per RAM pipeline stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trk_v    <= '0;
            trk_l    <= '0;
            inflight <= '0;
        end else begin
            trk_v[0] <= issue;
            trk_l[0] <= issue && issue_last;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                trk_v[i] <= trk_v[i-1];
                trk_l[i] <= trk_l[i-1];
            end
            if (issue && !push) begin
                inflight <= inflight + 1'b1;
            end else if (!issue && push) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

    stream_fifo #(
        .WIDTH (RW + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data ({trk_l[READ_LATENCY-1], rdata}),
        .pop       (pop),
        .pop_data  ({out_last, out_data}),
        .valid     (out_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_buffer_read_streamer.sv
module tb_buffer_read_streamer;
    import buffer_read_streamer_pkg::*;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int L     = 2;
    localparam int FD    = L + 2;
    localparam int RW    = FSIZE * 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0]   cmd_len = '0;
    logic [AW-1:0] raddr;
    logic [RW-1:0] rdata;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [RW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int max_credit = 0;

    always #5 clk = ~clk;

    buffer_read_streamer #(
        .DEPTH        (DEPTH),
        .WIDTH        (FSIZE),
        .WORDS        (32),
        .READ_LATENCY (L),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .raddr     (raddr),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    // RAM model: row i holds the value i, READ_LATENCY register stages.
    logic [AW-1:0] ram_pipe [L];
    always @(posedge clk) begin
        ram_pipe[0] <= raddr;
        for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign rdata = RW'(ram_pipe[L-1]);

    // Credit occupancy monitor.
    always @(negedge clk) begin
        if (rstn && (int'(dut.inflight) + int'(dut.fifo_count) > max_credit))
            max_credit = int'(dut.inflight) + int'(dut.fifo_count);
    end

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one command and consumes its rows; bp selects the backpressure pattern.
    task automatic run_cmd(input int base, input int len, input int first_row,
                           input int last_row, input bit bp, input string tag);
        int k, beats, first_k, budget;
        logic stall;
        logic [RW-1:0] held;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base  = AW'(base);
        cmd_len   = (AW + 1)'(len);
        chk({tag, "_cmd_ready_before"}, RW'(cmd_ready), RW'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 1; beats = 0; first_k = 0; stall = 1'b0; held = '0;
        budget = len * 4 + 100;
        while (beats < len && k < budget) begin
            if (bp) out_ready = (k >= 5 && k < 25) ? 1'b0 : 1'($urandom_range(0, 1));
            else    out_ready = 1'b1;
            if (stall) begin
                chk({tag, "_hold_valid"}, RW'(out_valid), RW'(1));
                chk({tag, "_hold_data"}, out_data, held);
            end
            if (out_valid && out_ready) begin
                if (beats == 0) begin
                    first_k = k;
                    if (!bp) chk({tag, "_latency"}, RW'(k), RW'(L + 2));
                end else if (!bp) begin
                    chk({tag, "_consecutive"}, RW'(k), RW'(first_k + beats));
                end
                chk({tag, "_data"}, out_data, RW'((first_row + beats) % DEPTH));
                chk({tag, "_last"}, RW'(out_last), RW'(beats == len - 1));
                if (beats == len - 1) chk({tag, "_last_row"}, out_data, RW'(last_row));
                beats++;
            end
            stall = out_valid && !out_ready;
            held  = out_data;
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b1;
        chk({tag, "_beats"}, RW'(beats), RW'(len));
        chk({tag, "_cmd_ready_after"}, RW'(cmd_ready), RW'(1));
        chk({tag, "_busy_after"}, RW'(busy), RW'(0));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, RW'(cmd_ready), RW'(1));
        chk({tag, "_out_valid"}, RW'(out_valid), RW'(0));
        chk({tag, "_out_last"}, RW'(out_last), RW'(0));
        chk({tag, "_busy"}, RW'(busy), RW'(0));
        chk({tag, "_raddr"}, RW'(raddr), RW'(0));
        chk({tag, "_out_data"}, out_data, RW'(0));
    endtask

    typedef struct {
        int    base;
        int    len;
        int    first_row;
        int    last_row;
        string name;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [AW-1:0] ra_before;
        bit saw_valid, saw_not_ready, saw_raddr_move;

        vecs[0] = '{10,  4,   10,  13,  "basic"};
        vecs[1] = '{510, 4,   510, 1,   "wrap"};
        vecs[2] = '{100, 1,   100, 100, "single"};
        vecs[3] = '{511, 2,   511, 0,   "wrap_edge"};
        vecs[4] = '{0,   512, 0,   511, "full"};

        #1;
        chk_reset_values("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i].base, vecs[i].len, vecs[i].first_row,
                    vecs[i].last_row, 1'b0, vecs[i].name);
        end

        // Zero-length command: accepted, no reads, no output.
        @(negedge clk);
        ra_before = raddr;
        cmd_valid = 1'b1;
        cmd_base  = AW'(77);
        cmd_len   = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        saw_valid = 0; saw_not_ready = 0; saw_raddr_move = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) saw_valid = 1;
            if (!cmd_ready) saw_not_ready = 1;
            if (raddr != ra_before) saw_raddr_move = 1;
            @(posedge clk); #1;
        end
        chk("zero_no_valid", RW'(saw_valid), RW'(0));
        chk("zero_cmd_ready", RW'(saw_not_ready), RW'(0));
        chk("zero_raddr_held", RW'(saw_raddr_move), RW'(0));

        // Backpressure with a long stall window.
        max_credit = 0;
        run_cmd(300, 16, 300, 315, 1'b1, "bp");
        checks++;
        if (max_credit > FD) begin
            errors++;
            $display("FAIL bp_credit: got %0d expected at most %0d", max_credit, FD);
        end

        // Reset in the middle of a command.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base  = AW'(20);
        cmd_len   = (AW + 1)'(8);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_reset_values("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        run_cmd(0, 2, 0, 1, 1'b0, "after_rst");
        saw_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) saw_valid = 1;
            @(posedge clk); #1;
        end
        chk("after_rst_no_stale", RW'(saw_valid), RW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
